// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: shares one SDRAM read port between two requesters.
// Grants fixed-length read bursts round-robin, issues sdram_dout_req for the
// owner, steers returned words to the owner only, and aborts stalled bursts.
module sdram_rd_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_ready_to_read,
  input  logic [15:0] sdram_dout,
  input  logic        sdram_dout_vld,
  output logic        sdram_dout_req,
  input  logic        req0,
  input  logic        req1,
  input  logic        en0,
  input  logic        en1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] din0,
  output logic [15:0] din1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BL_C     = CW'(BURST_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [SW-1:0] TO_C     = SW'(TIMEOUT);
  localparam logic [SW-1:0] STL_ONE  = SW'(1);
  localparam logic [SW-1:0] STL_ZERO = {SW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            owner_r, owner_s;
  logic            rr_r, rr_s;
  logic [CW-1:0]   issued_r, issued_s;
  logic [CW-1:0]   received_r, received_s;
  logic [SW-1:0]   stall_r, stall_s;
  logic            gnt0_s, gnt1_s;
  logic            tmo_s;
  logic            req_s;
  logic            pick_s;
  logic            abort_s;
  logic            finish_s;
  logic            elig0_s, elig1_s;
  logic            owner_en_s;

  // ready_to_read only matters when choosing a new owner (IDLE)
  assign elig0_s        = req0 & en0 & sdram_ready_to_read;
  assign elig1_s        = req1 & en1 & sdram_ready_to_read;
  assign owner_en_s     = owner_r ? en1 : en0;
  assign sdram_dout_req = req_s;

  // Next-state, counters and grant decode for the IDLE/BURST/DRAIN machine
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    rr_s       = rr_r;
    issued_s   = issued_r;
    received_s = received_r;
    stall_s    = stall_r;
    gnt0_s     = gnt0;
    gnt1_s     = gnt1;
    tmo_s      = 1'b0;
    req_s      = 1'b0;
    pick_s     = 1'b0;
    abort_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (elig0_s || elig1_s) begin
          if (elig0_s && elig1_s) begin
            pick_s = rr_r;
          end else begin
            pick_s = elig1_s;
          end
          owner_s    = pick_s;
          state_s    = BURST;
          gnt0_s     = ~pick_s;
          gnt1_s     = pick_s;
          issued_s   = CNT_ZERO;
          received_s = CNT_ZERO;
          stall_s    = STL_ZERO;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      BURST, DRAIN: begin
        // Requests stop the same cycle the owner's enable drops
        req_s    = (state_r == BURST) && (issued_r < BL_C) && owner_en_s;
        issued_s = issued_r + CW'(req_s);
        if (sdram_dout_vld && (received_r < BL_C)) begin
          received_s = received_r + CNT_ONE;
        end else begin
          received_s = received_r;
        end
        // Stall counting includes the request issued this cycle
        if (sdram_dout_vld) begin
          stall_s = STL_ZERO;
        end else if (issued_s > received_s) begin
          stall_s = stall_r + STL_ONE;
        end else begin
          stall_s = STL_ZERO;
        end
        abort_s = (stall_s == TO_C);
        if (state_r == BURST) begin
          finish_s = (received_s == BL_C);
        end else begin
          finish_s = (received_s == issued_s);
        end
        if (abort_s || finish_s) begin
          state_s = IDLE;
          gnt0_s  = 1'b0;
          gnt1_s  = 1'b0;
          rr_s    = ~owner_r;
          tmo_s   = abort_s;
          stall_s = STL_ZERO;
          if (abort_s) begin
            issued_s   = CNT_ZERO;
            received_s = CNT_ZERO;
          end else begin
            issued_s   = issued_s;
          end
        end else if ((state_r == BURST) && !owner_en_s) begin
          state_s = DRAIN;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
      end
    endcase
  end

  // State, arbitration and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      rr_r        <= 1'b0;
      issued_r    <= CNT_ZERO;
      received_r  <= CNT_ZERO;
      stall_r     <= STL_ZERO;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      rr_r        <= rr_s;
      issued_r    <= issued_s;
      received_r  <= received_s;
      stall_r     <= stall_s;
      gnt0        <= gnt0_s;
      gnt1        <= gnt1_s;
      busy        <= (state_s != IDLE);
      timeout_err <= tmo_s;
    end
  end

  // Return-data steering: only the owner sees data; words in IDLE are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din0 <= 16'h0000;
      din1 <= 16'h0000;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if ((state_r != IDLE) && sdram_dout_vld) begin
        if (owner_r) begin
          din1 <= sdram_dout;
          ack1 <= 1'b1;
        end else begin
          din0 <= sdram_dout;
          ack0 <= 1'b1;
        end
      end
    end
  end

endmodule
